// File: rtl/mem_arbiter.sv
// 2:1 arbiter sharing one split-handshake (req/addr_ok, later data_ok) memory port between
// an instruction master (m0) and a data master (m1). Define ARB_RR_EN for round-robin ties.
module mem_arbiter #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int OUTST = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            m0_req,
  input  logic            m0_write,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  output logic            m0_addr_ok,
  output logic            m0_data_ok,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_write,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  output logic            m1_addr_ok,
  output logic            m1_data_ok,
  output logic [DW-1:0]   m1_rdata,
  output logic            s_req,
  output logic            s_write,
  output logic [DW/8-1:0] s_wstrb,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  input  logic            s_addr_ok,
  input  logic            s_data_ok,
  input  logic [DW-1:0]   s_rdata,
  output logic [1:0]      dbg_state_o
);

  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CW = $clog2(OUTST + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(OUTST - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(OUTST);

  // Handshake: a request transfers in the cycle where s_req and s_addr_ok are both high;
  // a response transfers in the cycle s_data_ok is high, in request order.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e          state_q;
  logic            fifo_q [OUTST];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
`ifdef ARB_RR_EN
  logic            rr_last_q;
`endif

  logic            full;
  logic            winner;
  logic            win_req;
  logic            s_req_int;
  logic            push;
  logic            pop;
  logic            head_id;

  assign full = (count_q == FULL_CNT);

  always_comb begin
    winner  = 1'b0;
    win_req = 1'b0;
    unique case (state_q)
      LOCK0: begin
        winner  = 1'b0;
        win_req = m0_req;
      end
      LOCK1: begin
        winner  = 1'b1;
        win_req = m1_req;
      end
      default: begin
        win_req = m0_req | m1_req;
        if (m0_req && m1_req) begin
`ifdef ARB_RR_EN
          winner = ~rr_last_q;
`else
          winner = 1'b1;
`endif
        end else begin
          winner = m1_req;
        end
      end
    endcase
  end

  // A full order FIFO blocks new grants; a pop in the same cycle does not free a slot early.
  assign s_req_int = rst_b & win_req & ~full;
  assign push      = s_req_int & s_addr_ok;
  assign pop       = s_data_ok & (count_q != '0);
  assign head_id   = fifo_q[head_q];

  assign s_req   = s_req_int;
  assign s_write = s_req_int & (winner ? m1_write : m0_write);
  assign s_wstrb = s_req_int ? (winner ? m1_wstrb : m0_wstrb) : '0;
  assign s_addr  = s_req_int ? (winner ? m1_addr  : m0_addr)  : '0;
  assign s_wdata = s_req_int ? (winner ? m1_wdata : m0_wdata) : '0;

  assign m0_addr_ok = push & ~winner;
  assign m1_addr_ok = push &  winner;

  assign m0_data_ok = pop & ~head_id;
  assign m1_data_ok = pop &  head_id;
  assign m0_rdata   = (pop && !head_id) ? s_rdata : '0;
  assign m1_rdata   = (pop &&  head_id) ? s_rdata : '0;

  assign dbg_state_o = state_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = (head_q == LAST_PTR) ? '0 : head_q + 1'b1;
    end
    if (push) begin
      tail_d = (tail_q == LAST_PTR) ? '0 : tail_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < OUTST; i++) begin
        fifo_q[i] <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        fifo_q[tail_q] <= winner;
      end
    end
  end

  // A request left hanging without addr_ok keeps the port locked to its master until it
  // is accepted or withdrawn, so the slave never sees the address change under it.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (s_req_int && !s_addr_ok) begin
            state_q <= winner ? LOCK1 : LOCK0;
          end
        end
        LOCK0, LOCK1: begin
          if (!win_req || push) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_last_q <= 1'b1;
    end else if (push) begin
      rr_last_q <= winner;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations for the grant order, addresses and responses of each scenario.
module tb_mem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int OUTST = 2;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_b;
  logic            m0_req, m0_write, m1_req, m1_write;
  logic [DW/8-1:0] m0_wstrb, m1_wstrb;
  logic [AW-1:0]   m0_addr, m1_addr;
  logic [DW-1:0]   m0_wdata, m1_wdata;
  logic            m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [DW-1:0]   m0_rdata, m1_rdata;
  logic            s_req, s_write;
  logic [DW/8-1:0] s_wstrb;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic            s_addr_ok, s_data_ok;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      dbg_state_o;

  int total = 0;
  int bad   = 0;

  logic [0:0]    exp_q[$];
  int            lock_owner;
  int            last_win;
  int            grant_log[$];
  int            resp_who[$];
  logic [DW-1:0] resp_data[$];
  logic [AW-1:0] addr_log[$];

  mem_arbiter #(.AW(AW), .DW(DW), .OUTST(OUTST)) dut (
    .clk(clk), .rst_b(rst_b),
    .m0_req(m0_req), .m0_write(m0_write), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_write(s_write), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_req = 0; m0_write = 0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_write = 0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
    s_addr_ok = 0; s_data_ok = 0; s_rdata = '0;
  endtask

  task automatic drv_m0(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_req = req; m0_write = wr; m0_addr = a; m0_wdata = d; m0_wstrb = wr ? 4'hF : 4'h0;
  endtask

  task automatic drv_m1(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_req = req; m1_write = wr; m1_addr = a; m1_wdata = d; m1_wstrb = wr ? 4'h3 : 4'h0;
  endtask

  task automatic drv_s(input logic aok, input logic dok, input logic [DW-1:0] rd);
    s_addr_ok = aok; s_data_ok = dok; s_rdata = rd;
  endtask

  task automatic do_reset();
    idle_all();
    rst_b = 0;
    tick();
    tick();
    rst_b = 1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); resp_who.delete(); resp_data.delete(); addr_log.delete();
  endtask

  // scoreboard: model advances at the falling edge; inputs are stable until the next rising edge
  always @(negedge clk) begin
    bit full, wreq, e_sreq, hs, pop;
    int w;
    logic [0:0] head;
    if (!rst_b) begin
      chk("rst_s_req", s_req, 0);
      chk("rst_s_addr", s_addr, 0);
      chk("rst_addr_ok", {m0_addr_ok, m1_addr_ok}, 0);
      chk("rst_data_ok", {m0_data_ok, m1_data_ok}, 0);
      chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
      chk("rst_state", dbg_state_o, 0);
      exp_q.delete();
      lock_owner = -1;
      last_win   = 1;
    end else begin
      full = (exp_q.size() == OUTST);
      if (lock_owner >= 0) begin
        w    = lock_owner;
        wreq = (w == 1) ? m1_req : m0_req;
      end else begin
        wreq = m0_req | m1_req;
        if (m0_req && m1_req) w = RR ? (last_win == 1 ? 0 : 1) : 1;
        else w = m1_req ? 1 : 0;
      end
      e_sreq = wreq && !full;
      hs     = e_sreq && s_addr_ok;
      pop    = s_data_ok && exp_q.size() > 0;

      chk("s_req", s_req, e_sreq);
      if (e_sreq) begin
        chk("s_addr", s_addr, (w == 1) ? m1_addr : m0_addr);
        chk("s_write", s_write, (w == 1) ? m1_write : m0_write);
        chk("s_wstrb", s_wstrb, (w == 1) ? m1_wstrb : m0_wstrb);
        chk("s_wdata", s_wdata, (w == 1) ? m1_wdata : m0_wdata);
      end
      chk("m0_addr_ok", m0_addr_ok, hs && w == 0);
      chk("m1_addr_ok", m1_addr_ok, hs && w == 1);
      if (pop) begin
        head = exp_q[0];
        chk("m0_data_ok", m0_data_ok, head == 0);
        chk("m1_data_ok", m1_data_ok, head == 1);
        chk("m0_rdata", m0_rdata, (head == 0) ? s_rdata : '0);
        chk("m1_rdata", m1_rdata, (head == 1) ? s_rdata : '0);
      end else begin
        chk("data_ok_idle", {m0_data_ok, m1_data_ok}, 0);
      end

      if (s_req) addr_log.push_back(s_addr);
      if (m0_data_ok) begin resp_who.push_back(0); resp_data.push_back(m0_rdata); end
      if (m1_data_ok) begin resp_who.push_back(1); resp_data.push_back(m1_rdata); end

      if (pop) void'(exp_q.pop_front());
      if (hs) begin
        exp_q.push_back(w[0]);
        grant_log.push_back(w);
        last_win = w;
      end
      if (lock_owner >= 0) begin
        if (!wreq || hs) lock_owner = -1;
      end else if (e_sreq && !s_addr_ok) begin
        lock_owner = w;
      end
    end
  end

  initial begin
    int exp_g[4];
    idle_all();
    rst_b = 0;
    lock_owner = -1;
    last_win   = 1;
    tick();
    tick();
    rst_b = 1;

    // 1: single read with one-cycle response
    clear_logs();
    drv_m0(1, 0, 32'h100, 0); drv_s(1, 0, 0);
    tick();
    drv_m0(0, 0, 0, 0); drv_s(0, 1, 32'hDEADBEEF);
    tick();
    idle_all();
    tick();
    chk("t1_grants", grant_log.size(), 1);
    chk("t1_resp_n", resp_who.size(), 1);
    if (resp_who.size() == 1) begin
      chk("t1_resp_who", resp_who[0], 0);
      chk("t1_rdata", resp_data[0], 32'hDEADBEEF);
    end

    // 2: both request every cycle, slave answers one cycle after each accept
    do_reset();
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      drv_m0(1, 0, 32'h200 + k, 0); drv_m1(1, 0, 32'h300 + k, 0);
      drv_s(1, k > 0, 32'hA000 + k);
      tick();
    end
    drv_m0(0, 0, 0, 0); drv_m1(0, 0, 0, 0); drv_s(0, 1, 32'hA004);
    tick();
    idle_all();
    if (RR) exp_g = '{0, 1, 0, 1};
    else    exp_g = '{1, 1, 1, 1};
    chk("t2_grants", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) chk($sformatf("t2_grant%0d", k), grant_log[k], exp_g[k]);
    chk("t2_resp_n", resp_who.size(), 4);

    // 3: order FIFO fills, then a pop frees the port one cycle later
    do_reset();
    clear_logs();
    drv_m0(1, 0, 32'h40, 0); drv_s(1, 0, 0);
    tick(); tick(); tick();
    chk("t3_full_grants", grant_log.size(), 2);
    drv_s(1, 1, 32'h1234);
    tick();
    chk("t3_pop_cycle_grants", grant_log.size(), 2);
    drv_s(1, 0, 0);
    tick();
    chk("t3_resumed_grants", grant_log.size(), 3);
    drv_m0(0, 0, 0, 0); drv_s(0, 1, 32'h5678);
    tick(); tick();
    idle_all();
    tick();
    chk("t3_resp_n", resp_who.size(), 3);

    // 4: lock holds m0's address while m1 waits
    do_reset();
    clear_logs();
    drv_m0(1, 0, 32'h400, 0); drv_s(0, 0, 0);
    tick();
    drv_m1(1, 1, 32'h500, 32'h55);
    tick(); tick();
    drv_s(1, 0, 0);
    tick();
    drv_m0(0, 0, 0, 0); drv_s(1, 1, 32'hBB);
    tick();
    drv_m1(0, 0, 0, 0); drv_s(0, 1, 32'hCC);
    tick();
    idle_all();
    chk("t4_addr_n", addr_log.size(), 5);
    for (int k = 0; k < 4 && k < addr_log.size(); k++) chk($sformatf("t4_addr%0d", k), addr_log[k], 32'h400);
    if (addr_log.size() == 5) chk("t4_addr4", addr_log[4], 32'h500);
    chk("t4_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("t4_grant0", grant_log[0], 0);
      chk("t4_grant1", grant_log[1], 1);
    end

    // 5: interleaved read / write / read, responses routed in order
    do_reset();
    clear_logs();
    drv_m0(1, 0, 32'h600, 0); drv_s(1, 0, 0);
    tick();
    drv_m0(0, 0, 0, 0); drv_m1(1, 1, 32'h700, 32'hCAFE); drv_s(1, 1, 32'h11111111);
    tick();
    drv_m1(0, 0, 0, 0); drv_m0(1, 0, 32'h604, 0); drv_s(1, 1, 32'h99999999);
    tick();
    drv_m0(0, 0, 0, 0); drv_s(0, 1, 32'h22222222);
    tick();
    idle_all();
    chk("t5_resp_n", resp_who.size(), 3);
    if (resp_who.size() == 3) begin
      chk("t5_who0", resp_who[0], 0);
      chk("t5_who1", resp_who[1], 1);
      chk("t5_who2", resp_who[2], 0);
      chk("t5_rdata0", resp_data[0], 32'h11111111);
      chk("t5_rdata2", resp_data[2], 32'h22222222);
    end

    // 6: reset with two outstanding, stray responses afterwards are dropped
    do_reset();
    clear_logs();
    drv_m0(1, 0, 32'h800, 0); drv_s(1, 0, 0);
    tick();
    drv_m0(0, 0, 0, 0); drv_m1(1, 0, 32'h900, 0);
    tick();
    idle_all();
    rst_b = 0;
    tick();
    rst_b = 1;
    drv_s(0, 1, 32'h77777777);
    tick(); tick();
    idle_all();
    tick();
    chk("t6_grants", grant_log.size(), 2);
    chk("t6_resp_n", resp_who.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
